dmem_ctrl: RTL and testbench

- Memory-stage controller directly downstream of the ALU in the LEGv8 datapath.
- Takes the ALU result as a byte address and, for LDUR/STUR, runs a req/ack transaction with a variable-latency data memory.
- Stalls the core (PC and register-file write held) until the access completes.
- Rejects misaligned, out-of-range and conflicting accesses without touching memory, and reports bus timeouts.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_timeout_ctr.sv | 44 ++++
 rtl/dmem_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the LEGv8 memory-stage controller.
//   state_e          - controller states (IDLE, REQ, DONE)
//   DW_SHIFT         - byte-address to doubleword-index shift (8-byte words)
//   TIMEOUT_DEFAULT  - default bus timeout, in REQ cycles without mem_ack
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DW_SHIFT        = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: saturating up-counter for the REQ-phase bus timeout.
//   clk_i      in  system clock, rising edge
//   rst_ni     in  synchronous active-low reset
//   clr_i      in  force counter to 0 (priority over en_i)
//   en_i       in  count one more waited cycle
//   reached_o  out current cycle is the TIMEOUT-th enabled cycle since clear
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The count holds completed waits, so the TIMEOUT-th cycle sees TIMEOUT-1.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_o = (cnt_q == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-stage controller between the ALU and a variable-latency
// data memory. Runs one req/ack transaction per LDUR/STUR and stalls the core
// until it completes; rejects bad accesses and reports bus timeouts.
//   clk, reset (sync, active-low)
//   address, writeData, memRead, memWrite : instruction side, sampled in IDLE
//   readData  out registered load data
//   stall     out hold the current instruction
//   fault     out 1-cycle pulse, access rejected (misaligned/range/conflict)
//   busError  out 1-cycle pulse in DONE, access timed out
//   mem_req/mem_we/mem_addr/mem_wdata out registered memory request
//   mem_ack/mem_rdata in memory completion and read data
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_AW  = 9,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       address,
  input  logic [63:0]       writeData,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [63:0]       readData,
  output logic              stall,
  output logic              fault,
  output logic              busError,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic access, bad, to_reached;

  dmem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (state_q != REQ),
    .en_i     (state_q == REQ),
    .reached_o(to_reached)
  );

  assign access = memRead | memWrite;
  assign bad    = (memRead & memWrite)
                | (address[DW_SHIFT-1:0] != '0)
                | (address[63:MEM_AW+DW_SHIFT] != '0);

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    stall    = 1'b0;
    fault    = 1'b0;
    busError = 1'b0;

    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (access) begin
          if (bad) begin
            fault = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = memWrite;
            addr_d  = address[MEM_AW+DW_SHIFT-1:DW_SHIFT];
            wdata_d = writeData;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // Ack wins over a simultaneous timeout.
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else if (to_reached) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        busError = err_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign readData  = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized transaction-level bench for dmem_ctrl. The bench
// plays the data memory; for every cycle it queues the outputs the access
// rules demand, and a negedge process compares the DUT against that queue.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address, writeData;
  logic        memRead, memWrite;
  logic [63:0] readData;
  logic        stall, fault, busError;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_AW(9), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .readData(readData),
    .stall(stall), .fault(fault), .busError(busError),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        stall;
    logic        fault;
    logic        berr;
    logic        req;
    logic        chk_bus;
    logic        we;
    logic [8:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_m [512];
  logic [63:0] rd_m;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic f, input logic b, input logic r,
                      input logic cb, input logic w, input logic [8:0] ad,
                      input logic [63:0] wd, input logic [63:0] rdv);
    exp_t e;
    e.stall = s; e.fault = f; e.berr = b; e.req = r; e.chk_bus = cb;
    e.we = w; e.addr = ad; e.wdata = wd; e.rd = rdv;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", {63'b0, stall}, {63'b0, e.stall});
      chk("fault", {63'b0, fault}, {63'b0, e.fault});
      chk("busError", {63'b0, busError}, {63'b0, e.berr});
      chk("mem_req", {63'b0, mem_req}, {63'b0, e.req});
      chk("readData", readData, e.rd);
      if (e.chk_bus) begin
        chk("mem_we", {63'b0, mem_we}, {63'b0, e.we});
        chk("mem_addr", {55'b0, mem_addr}, {55'b0, e.addr});
        chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    address = rnd64(); writeData = rnd64();
    mem_ack = 1'($urandom % 2); mem_rdata = rnd64();
    push(0, 0, 0, 0, 0, 0, '0, '0, rd_m);
  endtask

  task automatic bad_access(input logic [63:0] a, input bit rd, input bit wr);
    @(posedge clk); #1;
    address = a; writeData = rnd64(); memRead = rd; memWrite = wr;
    mem_ack = 1'b0; mem_rdata = rnd64();
    push(0, 1, 0, 0, 0, 0, '0, '0, rd_m);
  endtask

  // lat = REQ cycle (1-based) in which ack arrives; 0 = never (timeout).
  task automatic good_access(input logic [63:0] a, input bit wr, input logic [63:0] wd,
                             input int unsigned lat, input bit late_ack,
                             output int unsigned stalls);
    int unsigned n;
    logic [8:0] idx;
    n = (lat == 0) ? 255 : lat;
    idx = a[11:3];
    stalls = 0;
    @(posedge clk); #1;
    address = a; writeData = wd; memRead = !wr; memWrite = wr;
    mem_ack = 1'b0; mem_rdata = rnd64();
    push(1, 0, 0, 0, 0, 0, '0, '0, rd_m);
    #1 if (stall) stalls++;
    for (int unsigned k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      address = rnd64(); writeData = rnd64();
      memRead = 1'($urandom); memWrite = 1'($urandom);
      mem_ack = (k == lat);
      mem_rdata = (k == lat && !wr) ? mem_m[idx] : rnd64();
      push(1, 0, 0, 1, 1, wr, idx, wd, rd_m);
      #1 if (stall) stalls++;
    end
    if (lat != 0) begin
      if (wr) mem_m[idx] = wd;
      else    rd_m = mem_m[idx];
    end else if (!wr) begin
      rd_m = '0;
    end
    // DONE: same instruction still presented; it must not start a new access.
    @(posedge clk); #1;
    address = a; writeData = wd; memRead = !wr; memWrite = wr;
    mem_ack = late_ack; mem_rdata = rnd64();
    push(0, 0, (lat == 0), 0, 0, 0, '0, '0, rd_m);
    #1 if (stall) stalls++;
  endtask

  initial begin
    int unsigned st;
    logic [63:0] a;
    reset = 1'b0; address = '0; writeData = '0; memRead = 1'b0; memWrite = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 512; i++) mem_m[i] = rnd64();
    rd_m = '0;

    @(posedge clk); #1;
    mem_ack = 1'b1;
    push(0, 0, 0, 0, 1, 0, '0, '0, '0);
    #1 chk("reset_readData", readData, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b0;
    push(0, 0, 0, 0, 1, 0, '0, '0, '0);

    // Directed load, ack in 2nd REQ cycle.
    mem_m[2] = 64'hDEADBEEF_00000001;
    good_access(64'h10, 1'b0, '0, 2, 1'b0, st);
    chk("load_stall_cycles", 64'(st), 64'd3);
    chk("load_data", readData, 64'hDEADBEEF_00000001);
    idle_cycle();

    // Directed store, ack in 1st REQ cycle.
    good_access(64'h18, 1'b1, 64'hA5, 1, 1'b0, st);
    chk("store_stall_cycles", 64'(st), 64'd2);
    chk("store_keeps_readData", readData, 64'hDEADBEEF_00000001);

    bad_access(64'h0C, 1'b1, 1'b0);
    #1 chk("misaligned_fault", {63'b0, fault}, 64'd1);
    bad_access(64'h20, 1'b1, 1'b1);
    #1 chk("conflict_fault", {63'b0, fault}, 64'd1);
    bad_access(64'h1000, 1'b1, 1'b0);
    #1 chk("range_fault", {63'b0, fault}, 64'd1);

    // Timeout with a late ack in DONE.
    good_access(64'h08, 1'b0, '0, 0, 1'b1, st);
    chk("timeout_stall_cycles", 64'(st), 64'd256);
    chk("timeout_busError", {63'b0, busError}, 64'd1);
    chk("timeout_readData", readData, 64'h0);
    idle_cycle();
    idle_cycle();

    // Ack in the last allowed cycle still succeeds.
    good_access(64'h08, 1'b0, '0, 255, 1'b0, st);
    chk("edge_ack_stall_cycles", 64'(st), 64'd256);
    chk("edge_ack_no_busError", {63'b0, busError}, 64'd0);

    // Reset during REQ, ack right after.
    @(posedge clk); #1;
    address = 64'h40; memRead = 1'b1; memWrite = 1'b0; mem_ack = 1'b0;
    push(1, 0, 0, 0, 0, 0, '0, '0, rd_m);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      memRead = 1'b0; address = rnd64();
      if (k == 3) reset = 1'b0;
      push(1, 0, 0, 1, 1, 0, 9'd8, '0, rd_m);
    end
    rd_m = '0;
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = rnd64();
    push(0, 0, 0, 0, 1, 0, '0, '0, '0);
    #1 chk("rst_mid_req_mem_req", {63'b0, mem_req}, 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    push(0, 0, 0, 0, 1, 0, '0, '0, '0);
    #1 chk("rst_ack_ignored", readData, 64'h0);

    // Back-to-back loads.
    good_access(64'h00, 1'b0, '0, 1, 1'b0, st);
    good_access(64'h08, 1'b0, '0, 2, 1'b0, st);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      a = {52'b0, 9'($urandom), 3'b0};
      case ($urandom % 6)
        0: idle_cycle();
        1: begin
          case ($urandom % 3)
            0: bad_access(a | 64'(1 + $urandom % 7), 1'($urandom), 1'b1);
            1: bad_access(a, 1'b1, 1'b1);
            default: bad_access(a | (64'h1 << (12 + $urandom % 52)), 1'b1, 1'b0);
          endcase
        end
        default: good_access(a, 1'($urandom), rnd64(),
                             ($urandom % 25 == 0) ? 0 : 1 + $urandom % 5,
                             1'($urandom), st);
      endcase
    end

    idle_cycle();
    idle_cycle();
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
